// File: rtl/piso_shift_controller_pkg.sv
// Shared types and helpers for the PISO shift controller.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width for a bit index 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift_controller_if.sv
// Producer/consumer handshake bundle of the PISO shift controller.
interface piso_shift_controller_if #(
  parameter int N = 8
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_out;
  logic         ser_last;
  logic         busy;
  logic         done;

  modport master (
    output flush, in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, ser_last, busy, done
  );

  modport slave (
    input  flush, in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, ser_last, busy, done
  );
endinterface

// File: rtl/piso_shift_controller_shift_reg.sv
// N-bit parallel-load shift register with zero fill; clear beats load beats shift.
module piso_shift_reg #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         clr_i,
  input  logic [N-1:0] d_i,
  output logic         sout_o
);
  logic [N-1:0] sr_q, sr_d, sr_shf;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_shf = {sr_q[N-2:0], 1'b0};
      assign sout_o = sr_q[N-1];
    end else begin : g_lsb
      assign sr_shf = {1'b0, sr_q[N-1:1]};
      assign sout_o = sr_q[0];
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (clr_i)        sr_d = '0;
    else if (load_i)  sr_d = d_i;
    else if (shift_i) sr_d = sr_shf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '0;
    else      sr_q <= sr_d;
  end
endmodule

// File: rtl/piso_shift_controller.sv
// Word-in / bit-out sequencer: FSM, bit counter, done pulse and handshakes.
module piso_shift_controller
  import piso_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  piso_shift_controller_if.slave  bus
);
  localparam int              CW   = cnt_w(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          sbit;
  logic          in_shift, last_bit, load, shift, clr;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = (cnt_q == LAST);
  assign load     = !in_shift && bus.in_valid && !bus.flush;
  // The final beat leaves the register untouched; only earlier beats shift.
  assign shift    = in_shift && bus.ser_ready && !last_bit && !bus.flush;
  assign clr      = in_shift && bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (bus.ser_ready) begin
            if (last_bit) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  piso_shift_reg #(.N(N), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .clr_i   (clr),
    .d_i     (bus.in_data),
    .sout_o  (sbit)
  );

  assign bus.in_ready  = !in_shift && !bus.flush;
  assign bus.ser_valid = in_shift;
  assign bus.busy      = in_shift;
  assign bus.ser_out   = in_shift && sbit;
  assign bus.ser_last  = in_shift && last_bit;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_piso_shift_controller.sv
// Bench for piso_shift_controller: one MSB-first and one LSB-first instance on shared stimulus.
module tb_piso_shift_controller;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0, in_valid = 1'b0, ser_ready = 1'b0;
  logic [N-1:0] in_data = '0;

  int tests = 0, fails = 0;
  int done_cnt = 0, sv_cnt = 0;

  // Reference: queues of bits still to be sent, in send order.
  bit qm[$];
  bit ql[$];
  bit mdone = 1'b0;

  piso_shift_controller_if #(.N(N)) ifm ();
  piso_shift_controller_if #(.N(N)) ifl ();

  assign ifm.flush = flush;  assign ifm.in_valid = in_valid;
  assign ifm.in_data = in_data; assign ifm.ser_ready = ser_ready;
  assign ifl.flush = flush;  assign ifl.in_valid = in_valid;
  assign ifl.in_data = in_data; assign ifl.ser_ready = ser_ready;

  piso_shift_controller #(.N(N), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(ifm));
  piso_shift_controller #(.N(N), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(ifl));

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       sr;
    logic       fl;
    logic       e_rdy;
    logic       e_sv;
    logic       e_om;
    logic       e_ol;
    logic       e_last;
    logic       e_done;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_n(input string nm, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_model();
    logic ne;
    ne = (qm.size() != 0);
    chk("m_in_ready",  ifm.in_ready,  !ne && !flush);
    chk("m_ser_valid", ifm.ser_valid, ne);
    chk("m_busy",      ifm.busy,      ne);
    chk("m_ser_out",   ifm.ser_out,   ne ? qm[0] : 1'b0);
    chk("m_ser_last",  ifm.ser_last,  qm.size() == 1);
    chk("m_done",      ifm.done,      mdone);
    chk("l_in_ready",  ifl.in_ready,  !ne && !flush);
    chk("l_ser_valid", ifl.ser_valid, ne);
    chk("l_busy",      ifl.busy,      ne);
    chk("l_ser_out",   ifl.ser_out,   ne ? ql[0] : 1'b0);
    chk("l_ser_last",  ifl.ser_last,  ql.size() == 1);
    chk("l_done",      ifl.done,      mdone);
  endtask

  task automatic mdl_clear();
    qm.delete(); ql.delete(); mdone = 1'b0;
  endtask

  task automatic mdl_edge();
    if (!rst) begin mdl_clear(); return; end
    mdone = 1'b0;
    if (qm.size() != 0) begin
      if (flush) begin
        qm.delete(); ql.delete();
      end else if (ser_ready) begin
        void'(qm.pop_front()); void'(ql.pop_front());
        mdone = (qm.size() == 0);
      end
    end else if (in_valid && !flush) begin
      for (int i = 0; i < N; i++) begin
        qm.push_back(in_data[N-1-i]);
        ql.push_back(in_data[i]);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic sr, input logic fl);
    in_valid = v; in_data = d; ser_ready = sr; flush = fl;
    @(negedge clk);
    chk_model();
    done_cnt += int'(ifm.done);
    sv_cnt   += int'(ifm.ser_valid);
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b1, 1'b0);
    repeat (N + 1) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] w;
    w = 8'h96;
    tv[0] = '{1'b1, 8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= N; i++)
      tv[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, w[N-i], w[i-1], logic'(i == N), 1'b0};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #2;
    chk_model();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Table: 0x96 through both orderings
    foreach (tv[i]) begin
      in_valid = tv[i].v; in_data = tv[i].d; ser_ready = tv[i].sr; flush = tv[i].fl;
      @(negedge clk);
      chk("t_in_ready", ifm.in_ready,  tv[i].e_rdy);
      chk("t_sv",       ifm.ser_valid, tv[i].e_sv);
      chk("t_out_msb",  ifm.ser_out,   tv[i].e_om);
      chk("t_out_lsb",  ifl.ser_out,   tv[i].e_ol);
      chk("t_last",     ifm.ser_last,  tv[i].e_last);
      chk("t_done",     ifm.done,      tv[i].e_done);
      chk_model();
      @(posedge clk);
      mdl_edge();
      #1;
    end

    // Back-pressure: 2 beats, 3 stalls, remaining 6 beats
    sv_cnt = 0;
    cyc(1'b1, 8'hF0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_n("bp_word_cycles", sv_cnt, 11);

    // Handshake: in_valid held across two words
    done_cnt = 0;
    cyc(1'b1, 8'h01, 1'b1, 1'b0);
    repeat (N + 1) cyc(1'b1, 8'h80, 1'b1, 1'b0);
    repeat (N + 2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_n("hs_done_pulses", done_cnt, 2);

    // Flush in IDLE blocks acceptance
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    // Flush at bit 4, then a clean word
    done_cnt = 0;
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_n("flush_no_done", done_cnt, 0);
    send(8'h55);
    // Flush coinciding with the last-bit beat
    done_cnt = 0;
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    repeat (N - 1) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_n("flush_last_no_done", done_cnt, 0);
    send(8'h55);

    // Asynchronous reset during bit 5
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0; ser_ready = 1'b1; flush = 1'b0;
    #2 rst = 1'b0;
    #1 mdl_clear();
    chk_model();
    @(posedge clk); #1;
    chk_model();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    done_cnt = 0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_n("rst_no_done", done_cnt, 0);
    send(8'h3C);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 19) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/piso_shift_controller.md
# piso_shift_controller

Sequencer for a parallel-in/serial-out shift register. It accepts an N-bit word over a valid/ready handshake, loads it into an internal N-bit shift register, and streams it out one bit per accepted serial beat, with back-pressure, a last-bit marker and a completion pulse. It sits between a word-oriented producer and any bit-serial consumer, such as a UART-style or SPI-style transmit path.

## Interface
- N, default 8: word width in bits; legal range N >= 2.
- MSB_FIRST, default 1: 1 = bit N-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the word in flight.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word.
- in_data  input  N  parallel word.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_ready  input  1  consumer accepts the current bit.
- ser_out  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is loaded and not yet fully sent.
- done  output  1  one-cycle pulse after the final bit is accepted.

## Operation
- States: IDLE and SHIFT.
- Bit counter cnt is $clog2(N) bits wide. It counts accepted bits from 0 to N-1. It never wraps past N-1.
- IDLE:
  - in_ready=1, ser_valid=0, busy=0.
  - When in_valid && in_ready: load in_data into the shift register, set cnt=0, go to SHIFT.
- SHIFT:
  - in_ready=0, ser_valid=1, busy=1.
  - ser_out = reg[N-1] if MSB_FIRST, else reg[0].
  - ser_last = (cnt == N-1).
- Beat: ser_valid && ser_ready.
  - On a beat with cnt < N-1: shift the register one position toward the output end, zero-fill, and increment cnt.
  - On a beat with cnt == N-1: go to IDLE and assert done in the next cycle. The register is not reloaded.
- Stall: while ser_ready=0 in SHIFT, the register, cnt, ser_out and ser_last hold. ser_valid stays 1.
- flush=1 in SHIFT:
  - Go to IDLE next cycle and clear the register and cnt.
  - No done pulse, even if the same cycle is a last-bit beat. flush wins.
- flush=1 in IDLE: in_ready is forced to 0 that cycle and no word is accepted.
- No back-to-back acceptance: in_ready depends only on state and flush. There is no combinational path from ser_ready or in_valid to in_ready.
- Reset (rst=0, asynchronous):
  - state=IDLE; register, cnt and done cleared.
  - Outputs while in reset: ser_valid=0, ser_out=0, ser_last=0, busy=0, done=0, in_ready=1.
  - Reset asserted mid-word discards the word with no done pulse.

## Timing
- Accept at edge k. Then ser_valid=1 and the first bit is valid from cycle k+1.
- With ser_ready held at 1: bits are sent in cycles k+1 through k+N.
- ser_last=1 in cycle k+N.
- done=1 and in_ready=1 in cycle k+N+1.
- The next word can be accepted at the end of cycle k+N+1, so sustained throughput is one word per N+1 cycles.
- Each cycle with ser_ready=0 extends the word by one cycle.
- done is registered and lasts exactly one cycle.
- ser_out, ser_last and busy are glitch-free functions of registered state.

## Structure
- Shared package piso_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the counter-width function, or use $clog2 directly.
- One sub-module, piso_shift_reg:
  - N-bit register with asynchronous active-low reset, synchronous load, shift enable, synchronous clear, and MSB_FIRST direction parameter;
  - zero-fill on shift.
- The controller holds the FSM, cnt, done and the handshake logic.

## Test plan
- Basic MSB-first: N=8, MSB_FIRST=1, ser_ready=1, send 0x96 → ser_out 1,0,0,1,0,1,1,0 in cycles k+1..k+8; ser_last only at k+8; done at k+9.
- Basic LSB-first: MSB_FIRST=0, send 0x96 → ser_out 0,1,1,0,1,0,0,1; done one cycle after the 8th beat.
- Back-pressure: drop ser_ready for 3 cycles after bit 2 of 0xF0 → ser_out holds at 1 with ser_valid=1; the word completes in 11 cycles; the bit sequence is unchanged.
- Handshake: hold in_valid=1 with 0x01 then 0x80 → in_ready=0 throughout SHIFT; the second word is accepted only in the IDLE cycle; exactly 2 done pulses.
- Flush: flush asserted at bit 4 of 0xAA, including a case where flush coincides with the last-bit beat → IDLE next cycle, busy=0, no done, next word 0x55 serializes correctly.
- Reset mid-word: rst low during bit 5 → all outputs at reset values immediately, in_ready=1; after release, 0x3C serializes correctly.
